weight_buffer: RTL and testbench

Parametrised successor to the fixed 8-entry, 4-output weight memory. Holds DEPTH weights of DATA_W bits, loaded as a sequential valid/ready stream. Serves LANES consecutive weights per read request to the systolic array feeder, with wrap-around addressing and 1-cycle registered latency. A small FSM sequences load and read phases, and a read-valid flag qualifies the output data.

---
 rtl/weight_buffer.sv | 170 +++++++++++++++++
 tb/tb_weight_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer.sv
// weight_buffer
//   Parametrised weight memory for the systolic array feeder. DEPTH weights of
//   DATA_W bits are loaded as a sequential valid/ready stream, then served LANES
//   consecutive weights per read request with wrap-around addressing and a
//   single registered cycle of latency.
//
//   Optional feature macro: WEIGHT_BUF_ZERO_FILL_EN
//     defined   : lanes whose wrapped index is >= wcount read as zero
//     undefined : those lanes return whatever the memory still holds
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ld_start            pulse: begin a new load at entry 0 (accepted in any state)
//   ld_valid/ld_ready   load beat handshake
//   ld_data, ld_last    load payload, final-beat marker
//   rd_req/rd_ready     read request handshake
//   rd_addr             base entry of the read
//   rd_valid            1-cycle pulse qualifying rd_data / rd_err
//   rd_data             lane k at bits [k*DATA_W +: DATA_W]
//   rd_err              rd_addr was >= DEPTH (rd_data forced to zero)
//   loaded              a complete load is present
//   wcount              entries written by the last or current load

module weight_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_start,
  input  logic                    ld_valid,
  input  logic [DATA_W-1:0]       ld_data,
  input  logic                    ld_last,
  output logic                    ld_ready,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    rd_ready,
  output logic                    rd_valid,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic                    rd_err,
  output logic                    loaded,
  output logic [ADDR_W:0]         wcount
);

  // Memory is indexed with exactly as many bits as DEPTH needs; ADDR_W may be
  // wider so that out-of-range base addresses can be presented and flagged.
  localparam int                MEM_AW   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [MEM_AW-1:0] LAST_PTR = MEM_AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SERVE
  } state_t;

  state_t              state_reg;
  logic [MEM_AW-1:0]   wptr_reg;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ld_beat;
  logic                ld_end;
  logic                rd_acc;
  logic                rd_oob;
  logic [LANES*DATA_W-1:0] lane_data;

  // ld_start takes priority over anything else in the same cycle: a beat or a
  // read request arriving alongside it is discarded.
  assign ld_beat = ld_valid & ld_ready & ~ld_start;
  assign ld_end  = ld_beat & (ld_last | (wptr_reg == LAST_PTR));
  assign rd_acc  = rd_req & rd_ready & ~ld_start;
  assign rd_oob  = {1'b0, rd_addr} >= DEPTH_W;

  // Write port (memory contents are intentionally not reset).
  always_ff @(posedge clk) begin
    if (ld_beat) begin
      mem[wptr_reg] <= ld_data;
    end
  end

  // Per-lane wrapped index. The base is < DEPTH whenever the result is used,
  // and LANES <= DEPTH, so one compare-and-subtract is enough even for a
  // non-power-of-two DEPTH.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ADDR_W:0]   lane_sum;
      logic [ADDR_W:0]   lane_idx;
      logic [DATA_W-1:0] lane_word;
      logic              lane_unused;

      assign lane_sum    = {1'b0, rd_addr} + (ADDR_W+1)'(gi);
      assign lane_idx    = (lane_sum >= DEPTH_W) ? (lane_sum - DEPTH_W) : lane_sum;
      // Upper index bits only matter for the zero-fill compare.
      assign lane_unused = ^lane_idx[ADDR_W:MEM_AW];

`ifdef WEIGHT_BUF_ZERO_FILL_EN
      assign lane_word = (lane_idx >= wcount) ? '0 : mem[lane_idx[MEM_AW-1:0]];
`else
      assign lane_word = mem[lane_idx[MEM_AW-1:0]];
`endif

      assign lane_data[gi*DATA_W +: DATA_W] = rd_oob ? '0 : lane_word;
    end
  endgenerate

  // Control FSM plus all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wptr_reg  <= '0;
      ld_ready  <= 1'b0;
      rd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_err    <= 1'b0;
      loaded    <= 1'b0;
      wcount    <= '0;
    end else begin
      // Read pipeline: rd_data / rd_err only change on an accepted request.
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= lane_data;
        rd_err  <= rd_oob;
      end

      if (ld_start) begin
        // New load from entry 0, from any state (restart if already loading).
        state_reg <= LOAD;
        ld_ready  <= 1'b1;
        rd_ready  <= 1'b0;
        wptr_reg  <= '0;
        wcount    <= '0;
        loaded    <= 1'b0;
      end else begin
        unique case (state_reg)
          IDLE: begin
            ld_ready <= 1'b0;
            rd_ready <= 1'b0;
          end
          LOAD: begin
            if (ld_beat) begin
              wptr_reg <= wptr_reg + MEM_AW'(1);
              if (wcount != DEPTH_W) begin
                wcount <= wcount + (ADDR_W+1)'(1);
              end
              if (ld_end) begin
                state_reg <= SERVE;
                ld_ready  <= 1'b0;
                rd_ready  <= 1'b1;
                loaded    <= 1'b1;
              end
            end
          end
          SERVE: begin
            ld_ready <= 1'b0;
            rd_ready <= 1'b1;
          end
          default: begin
            state_reg <= IDLE;
            ld_ready  <= 1'b0;
            rd_ready  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer.sv
// tb_weight_buffer
//   Scoreboard bench for weight_buffer (DATA_W=8, DEPTH=16, LANES=4). ADDR_W is
//   widened to 5 so base addresses >= DEPTH can be driven. Expected read
//   results are pushed when a request is driven and compared when rd_valid is
//   sampled on the falling edge of the due cycle.

module tb_weight_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LANES  = 4;
  localparam int ADDR_W = 5;

`ifdef WEIGHT_BUF_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    ld_start;
  logic                    ld_valid;
  logic [DATA_W-1:0]       ld_data;
  logic                    ld_last;
  logic                    ld_ready;
  logic                    rd_req;
  logic [ADDR_W-1:0]       rd_addr;
  logic                    rd_ready;
  logic                    rd_valid;
  logic [LANES*DATA_W-1:0] rd_data;
  logic                    rd_err;
  logic                    loaded;
  logic [ADDR_W:0]         wcount;

  weight_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .LANES (LANES),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ld_start(ld_start),
    .ld_valid(ld_valid),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .ld_ready(ld_ready),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .loaded  (loaded),
    .wcount  (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cycle_cnt = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  // Reference model of the buffer contents.
  logic [7:0]  m_mem [DEPTH];
  int          m_wptr;
  int          m_wcount;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] model_rd(input int addr);
    logic [31:0] d;
    logic [7:0]  w;
    int          idx;
    d = '0;
    if (addr >= DEPTH) return {1'b1, 32'h0};
    for (int k = 0; k < LANES; k++) begin
      idx = (addr + k) % DEPTH;
      w   = m_mem[4'(idx)];
      if (ZF && idx >= m_wcount) w = 8'h00;
      d[k*8 +: 8] = w;
    end
    return {1'b0, d};
  endfunction

  task automatic rd_push(input int addr, input logic [31:0] d, input logic e);
    exp_t x;
    rd_req  = 1'b1;
    rd_addr = 5'(addr);
    x.cyc   = cycle_cnt + 1;
    x.addr  = addr;
    x.data  = d;
    x.err   = e;
    sb.push_back(x);
    tick();
    rd_req  = 1'b0;
  endtask

  task automatic rd_model(input int addr);
    logic [32:0] r;
    r = model_rd(addr);
    rd_push(addr, r[31:0], r[32]);
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    m_wptr   = 0;
    m_wcount = 0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    m_mem[4'(m_wptr)] = d;
    m_wptr++;
    if (m_wcount < DEPTH) m_wcount++;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load_seq(input logic [7:0] base, input int n, input logic with_last);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 8'(i), with_last && (i == n - 1));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ld_ready"}, 64'(ld_ready), 64'(0));
    check({tag, "_rd_ready"}, 64'(rd_ready), 64'(0));
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
    check({tag, "_rd_data"},  64'(rd_data),  64'(0));
    check({tag, "_rd_err"},   64'(rd_err),   64'(0));
    check({tag, "_loaded"},   64'(loaded),   64'(0));
    check({tag, "_wcount"},   64'(wcount),   64'(0));
  endtask

  // Response monitor: one comparison set per expected read, and any rd_valid
  // not owed to a scoreboard entry is flagged.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cycle_cnt) begin
      mon_e = sb.pop_front();
      check("rd_valid", 64'(rd_valid), 64'(1));
      check("rd_data",  64'(rd_data),  64'(mon_e.data));
      check("rd_err",   64'(rd_err),   64'(mon_e.err));
      $display("read addr=%0d data=0x%08h err=%0b (want 0x%08h err=%0b)",
               mon_e.addr, rd_data, rd_err, mon_e.data, mon_e.err);
    end else if (rd_valid) begin
      check("spurious_rd_valid", 64'(rd_valid), 64'(0));
    end
  end

  initial begin
    rst      = 1'b1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;
    rd_req   = 1'b0;
    rd_addr  = '0;
    m_wptr   = 0;
    m_wcount = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Read request while IDLE is ignored.
    rd_req  = 1'b1;
    rd_addr = 5'd0;
    tick();
    rd_req  = 1'b0;
    check("idle_rd_ready", 64'(rd_ready), 64'(0));

    // Test 1: full load, then read at 0.
    start_load();
    check("t1_ld_ready", 64'(ld_ready), 64'(1));
    check("t1_loaded_clr", 64'(loaded), 64'(0));
    load_seq(8'h10, 16, 1'b1);
    check("t1_loaded", 64'(loaded), 64'(1));
    check("t1_wcount", 64'(wcount), 64'(16));
    check("t1_ld_ready_off", 64'(ld_ready), 64'(0));
    check("t1_rd_ready", 64'(rd_ready), 64'(1));
    rd_push(0, 32'h13121110, 1'b0);

    // Test 2: wrap, out-of-range, and hold of rd_data.
    rd_push(14, 32'h11101F1E, 1'b0);
    rd_push(16, 32'h0, 1'b1);
    rd_push(31, 32'h0, 1'b1);
    rd_push(5, 32'h18171615, 1'b0);
    repeat (3) tick();
    check("t2_rd_data_hold", 64'(rd_data), 64'(32'h18171615));
    check("t2_rd_err_hold", 64'(rd_err), 64'(0));

    // Test 3: short load with a mid-load restart, then zero-fill/stale read.
    start_load();
    send_beat(8'hEE, 1'b0);
    send_beat(8'hEF, 1'b0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'hCC;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    m_wptr   = 0;
    m_wcount = 0;
    check("t3_restart_wcount", 64'(wcount), 64'(0));
    check("t3_restart_ld_ready", 64'(ld_ready), 64'(1));
    load_seq(8'hA1, 3, 1'b1);
    check("t3_wcount", 64'(wcount), 64'(3));
    check("t3_loaded", 64'(loaded), 64'(1));
    rd_push(1, ZF ? 32'h0000A3A2 : 32'h1413A3A2, 1'b0);
    rd_model(14);

    // Test 4: back-to-back reads, one response per request in order.
    for (int a = 0; a < 4; a++) rd_model(a);
    repeat (3) tick();

    // Test 5: ld_start beats rd_req in SERVE.
    ld_start = 1'b1;
    rd_req   = 1'b1;
    rd_addr  = 5'd2;
    tick();
    ld_start = 1'b0;
    rd_req   = 1'b0;
    m_wptr   = 0;
    m_wcount = 0;
    check("t5_ld_ready", 64'(ld_ready), 64'(1));
    check("t5_loaded", 64'(loaded), 64'(0));
    check("t5_rd_ready", 64'(rd_ready), 64'(0));
    check("t5_wcount", 64'(wcount), 64'(0));
    repeat (2) tick();

    // Test 6a: reset mid-load after 5 beats.
    load_seq(8'h50, 5, 1'b0);
    check("t6_wcount5", 64'(wcount), 64'(5));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("t6a_async");
    tick();
    tick();
    rst      = 1'b0;
    m_wcount = 0;
    start_load();
    load_seq(8'h60, 16, 1'b1);
    check("t6a_wcount", 64'(wcount), 64'(16));
    rd_model(15);

    // Test 6b: reset right after a read accept drops the response.
    rd_req  = 1'b1;
    rd_addr = 5'd3;
    tick();
    rst     = 1'b1;
    rd_req  = 1'b0;
    #1;
    check_all_zero("t6b_async");
    tick();
    rst      = 1'b0;
    m_wcount = 0;
    tick();
    start_load();
    load_seq(8'h70, 4, 1'b1);
    check("t6b_wcount", 64'(wcount), 64'(4));
    check("t6b_loaded", 64'(loaded), 64'(1));
    rd_model(2);

    repeat (4) tick();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
